sprite_row_fetcher: RTL

- Reads one row of a 21x21 palette sprite ROM per video line into a local line buffer.
- Replays that row as per-pixel color plus opacity while the line is drawn.
- Drives the ROM's 9-bit `read_address` and consumes its combinational 24-bit `output_color`.
- Sits between the VGA timing controller and the color mapper; one instance per on-screen sprite.

---
 rtl/sprite_row_fetcher.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sprite_row_fetcher.sv
// Fetches one 21-pixel row of a palette sprite ROM per video line and replays it per DrawX.
// Define SPRITE_FLIP_EN to honor the flip input (horizontal mirror); otherwise flip is ignored.
//
// state | meaning
// IDLE  | no fetch in progress; rom_addr held at 0
// FETCH | streaming base+col from the ROM into the line buffer, one pixel per cycle
module sprite_row_fetcher #(
  parameter int          SPR_W  = 21,
  parameter int          SPR_H  = 21,
  parameter int          ADDR_W = 9,
  parameter logic [23:0] TRANSP = 24'h800080
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              line_start,
  input  logic [9:0]        next_y,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_color,
  input  logic [9:0]        DrawX,
  output logic              fetch_busy,
  output logic              pix_valid,
  output logic [23:0]       pix_color
);

  localparam int COL_W = $clog2(SPR_W);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              line_hit_q, line_hit_d;
  logic [9:0]        sprite_x_q, sprite_x_d;
  logic              pix_valid_q, pix_valid_d;
  logic [23:0]       pix_color_q, pix_color_d;

  logic [23:0]       buf_q    [0:SPR_W-1];
  logic              opaque_q [0:SPR_W-1];

  logic              wr_en;
  logic [COL_W-1:0]  wr_idx;
  logic [10:0]       row;
  logic              row_in;
  logic [10:0]       dx;
  logic              dx_in;
  logic [COL_W-1:0]  dx_idx;

`ifdef SPRITE_FLIP_EN
  logic flip_q, flip_d;
`else
  logic unused_flip;
  assign unused_flip = flip;
`endif

  // Row/column offsets are 11-bit signed so that off-screen or wrapped positions never alias into range
  assign row    = {1'b0, next_y} - {1'b0, sprite_y};
  assign row_in = !row[10] && (row < 11'(SPR_H));
  assign dx     = {1'b0, DrawX} - {1'b0, sprite_x_q};
  assign dx_in  = !dx[10] && (dx < 11'(SPR_W));
  assign dx_idx = dx_in ? dx[COL_W-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    col_d      = col_q;
    line_hit_d = line_hit_q;
    sprite_x_d = sprite_x_q;
    wr_en      = 1'b0;
`ifdef SPRITE_FLIP_EN
    flip_d     = flip_q;
    wr_idx     = flip_q ? (COL_W'(SPR_W - 1) - col_q) : col_q;
`else
    wr_idx     = col_q;
`endif

    if (line_start) begin
      // A new request always wins, even on the last fetch cycle, so a partial row is never marked valid
      sprite_x_d = sprite_x;
      line_hit_d = 1'b0;
      col_d      = '0;
      if (row_in) begin
        state_d = FETCH;
        base_d  = ADDR_W'(row) * ADDR_W'(SPR_W);
`ifdef SPRITE_FLIP_EN
        flip_d  = flip;
`endif
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == FETCH) begin
      wr_en = 1'b1;
      col_d = col_q + COL_W'(1);
      if (col_q == COL_W'(SPR_W - 1)) begin
        line_hit_d = 1'b1;
        col_d      = '0;
        state_d    = IDLE;
      end
    end
  end

  always_comb begin
    pix_valid_d = line_hit_q && dx_in && opaque_q[dx_idx];
    pix_color_d = pix_valid_d ? buf_q[dx_idx] : 24'h0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      col_q       <= '0;
      line_hit_q  <= 1'b0;
      sprite_x_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
`ifdef SPRITE_FLIP_EN
      flip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      col_q       <= col_d;
      line_hit_q  <= line_hit_d;
      sprite_x_q  <= sprite_x_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
`ifdef SPRITE_FLIP_EN
      flip_q      <= flip_d;
`endif
    end
  end

  // Buffer contents need no reset; they are masked by line_hit until a full row has landed
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      buf_q[wr_idx]    <= rom_color;
      opaque_q[wr_idx] <= (rom_color != TRANSP);
    end
  end

  assign rom_addr   = (state_q == FETCH) ? (base_q + ADDR_W'(col_q)) : '0;
  assign fetch_busy = (state_q == FETCH);
  assign pix_valid  = pix_valid_q;
  assign pix_color  = pix_color_q;

endmodule
